ram_port_arbiter: RTL

- Arbitrates the single data RAM between two requesters: port 0 (core load/store path) and port 1 (debug/program loader).
- Sits between the requesters and the data RAM.
- The data RAM is synchronous: read data is valid in the cycle after an enabled access, and writes are byte-masked.
- Single-outstanding, 3-cycle transaction sequencer with round-robin or fixed-priority grant.

---
 rtl/ram_port_arbiter.sv | 160 ++++++++++++++++
 1 files changed

// File: rtl/ram_port_arbiter.sv
// ram_port_arbiter: shares one synchronous, byte-masked data RAM between the
// core load/store path (port 0) and the debug/program loader (port 1).
// One transaction is in flight at a time and takes three cycles:
// IDLE (grant/handshake) -> ISSUE (RAM access) -> RESP (response pulse).
// Ties go round-robin, or always to port 0 when FIXED_PRIO is set.
module ram_port_arbiter #(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int MASK_W     = 4,   // one bit per byte lane: DATA_W/8
    parameter int FIXED_PRIO = 0
) (
    input  logic              clk,
    input  logic              reset_n,

    input  logic              p0_valid,
    output logic              p0_ready,
    input  logic [ADDR_W-1:0] p0_addr,
    input  logic [DATA_W-1:0] p0_wdata,
    input  logic [MASK_W-1:0] p0_wr_mask,
    output logic              p0_rvalid,
    output logic [DATA_W-1:0] p0_rdata,

    input  logic              p1_valid,
    output logic              p1_ready,
    input  logic [ADDR_W-1:0] p1_addr,
    input  logic [DATA_W-1:0] p1_wdata,
    input  logic [MASK_W-1:0] p1_wr_mask,
    output logic              p1_rvalid,
    output logic [DATA_W-1:0] p1_rdata,

    output logic              ram_en,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_wdata,
    output logic [MASK_W-1:0] ram_wr_mask,
    input  logic [DATA_W-1:0] ram_rdata
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_RESP  = 2'd2
    } state_e;

    state_e            state_q, state_d;
    logic              last_grant_q, last_grant_d;   // port that won the previous handshake
    logic              gnt_id_q, gnt_id_d;           // port owning the in-flight transaction
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [MASK_W-1:0] mask_q, mask_d;
    logic [DATA_W-1:0] p0_rdata_q, p0_rdata_d;
    logic [DATA_W-1:0] p1_rdata_q, p1_rdata_d;

    logic              win_valid;
    logic              win_id;
    logic              grant_ok;
    logic [DATA_W-1:0] resp_data;

    // The RAM bus always shows the latched request; it only changes at a
    // handshake, so address and write data hold their last values otherwise.
    assign ram_addr  = addr_q;
    assign ram_wdata = wdata_q;

    // A write is acknowledged with zero data; a read returns the RAM word.
    assign resp_data = (mask_q == '0) ? ram_rdata : '0;

    // Winner selection from the current valids; ties depend on the policy.
    always_comb begin
        win_valid = p0_valid | p1_valid;
        win_id    = 1'b0;
        if (p0_valid && p1_valid) begin
            win_id = (FIXED_PRIO != 0) ? 1'b0 : ~last_grant_q;
        end else if (p1_valid) begin
            win_id = 1'b1;
        end
    end

    // Ready is combinational, so it is also masked by reset to keep every
    // output low while reset_n is asserted.
    assign grant_ok = reset_n & win_valid;

    // Next-state logic and all sequencer outputs.
    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        gnt_id_d     = gnt_id_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        mask_d       = mask_q;
        p0_rdata_d   = p0_rdata_q;
        p1_rdata_d   = p1_rdata_q;

        p0_ready     = 1'b0;
        p1_ready     = 1'b0;
        p0_rvalid    = 1'b0;
        p1_rvalid    = 1'b0;
        p0_rdata     = p0_rdata_q;
        p1_rdata     = p1_rdata_q;
        ram_en       = 1'b0;
        ram_wr_mask  = '0;

        case (state_q)
            S_IDLE: begin
                if (grant_ok) begin
                    p0_ready     = ~win_id;
                    p1_ready     = win_id;
                    gnt_id_d     = win_id;
                    last_grant_d = win_id;
                    addr_d       = win_id ? p1_addr    : p0_addr;
                    wdata_d      = win_id ? p1_wdata   : p0_wdata;
                    mask_d       = win_id ? p1_wr_mask : p0_wr_mask;
                    state_d      = S_ISSUE;
                end
            end
            S_ISSUE: begin
                ram_en      = 1'b1;
                ram_wr_mask = mask_q;
                state_d     = S_RESP;
            end
            S_RESP: begin
                if (gnt_id_q) begin
                    p1_rvalid  = 1'b1;
                    p1_rdata   = resp_data;
                    p1_rdata_d = resp_data;
                end else begin
                    p0_rvalid  = 1'b1;
                    p0_rdata   = resp_data;
                    p0_rdata_d = resp_data;
                end
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and request registers; reset drops any in-flight transaction.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= S_IDLE;
            last_grant_q <= 1'b1;
            gnt_id_q     <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
            mask_q       <= '0;
            p0_rdata_q   <= '0;
            p1_rdata_q   <= '0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            gnt_id_q     <= gnt_id_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            mask_q       <= mask_d;
            p0_rdata_q   <= p0_rdata_d;
            p1_rdata_q   <= p1_rdata_d;
        end
    end

endmodule
